spu_register_table: RTL and testbench
=====================================

Name: spu_register_table

Overview:
- Architectural register file for the dual-issue SPU pipeline: 128 registers × 128 bits.
- Decodes source-register fields from the even-pipe and odd-pipe instructions according to a pre-decoded format code.
- Returns operand values one cycle later: three operands for even, two for odd.
- Accepts one writeback per pipe per cycle.

Parameters:
- NUM_REGS, 128, number of registers. Addresses are 7 bits, so the value is fixed at 128.
- DATA_W, 128, register width in bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_even  in  [0:31]  even-pipe instruction word; bit 0 is the MSB.
- instr_odd  in  [0:31]  odd-pipe instruction word.
- format_even  in  [2:0]  even-pipe instruction format code.
- format_odd  in  [2:0]  odd-pipe instruction format code.
- ra_even  out  [0:127]  even operand RA.
- rb_even  out  [0:127]  even operand RB.
- rc_even  out  [0:127]  even operand RC.
- ra_odd  out  [0:127]  odd operand RA.
- rb_odd  out  [0:127]  odd operand RB.
- rt_addr_even  in  [0:6]  even writeback register address.
- rt_addr_odd  in  [0:6]  odd writeback register address.
- rt_even  in  [0:127]  even writeback data.
- rt_odd  in  [0:127]  odd writeback data.
- reg_write_even  in  1  even write enable.
- reg_write_odd  in  1  odd write enable.

Behaviour:
- Clock/reset:
  - Reset is synchronous and active-high on clk.
  - On a reset edge, all 128 registers and all five operand outputs clear to 0.
  - Writes are ignored on a reset edge.
- Format codes and register fields (big-endian bit numbering):
  - 0 RRR: rt 4:10, rb 11:17, ra 18:24, rc 25:31.
  - 1 RR: rb 11:17, ra 18:24.
  - 2 RI7: ra 18:24.
  - 3 RI10: ra 18:24.
  - 4 RI16: no register sources.
  - 5 RI18: no register sources.
  - 6–7: no register sources.
- Source selection per format:
  - RRR reads ra, rb, rc.
  - RR reads ra, rb.
  - RI7 and RI10 read ra only.
  - Any operand the format does not read outputs 0.
  - Odd pipe has no rc output; an RRR decode on odd reads ra and rb only.
- Read latency: operand outputs are registered. Values for the instruction/format sampled at edge N appear after edge N and hold until the next edge.
- Writes: on each non-reset edge, reg[rt_addr_even] ← rt_even if reg_write_even, and reg[rt_addr_odd] ← rt_odd if reg_write_odd.
- Same-edge write conflict: both pipes writing the same address leaves the register holding rt_odd.
- Write-through forwarding:
  - If a source address decoded at edge N matches a write address enabled at edge N, the operand output takes the write data, not the stale register value.
  - If both pipes write that address, rt_odd is forwarded.
- All five operands are independent. Any number may alias the same register, including all reading one register that is being written.
- Register 0 is an ordinary register: writable and readable, no hardwired value.
- X/undefined format or instruction bits do not corrupt register contents; only the write ports modify state.

Test Plan:
- Reset: hold reset 2 edges after writing reg 7 = 0xFF..F. Required: all outputs 0, and a later RR read of reg 7 returns 0.
- Basic write then read:
  - Edge 1: reg_write_even=1, rt_addr_even=5, rt_even=0x000A_0000_..._0; also present instr_even=0x0BE0C205 (shlh rb=3, ra=4, rt=5), format_even=1. Required: ra_even=0, rb_even=0.
  - Edge 2: RR instruction with ra=5, rb=3. Required: ra_even=0x000A0…0, rb_even=0.
- Forwarding: same-edge write of reg 9=0x1234…, with odd RR instruction ra=9, rb=9. Required: ra_odd=rb_odd=0x1234… after that edge.
- Dual-write conflict: both pipes write reg 20 (even=0xAA…, odd=0x55…), then read reg 20. Required: 0x55…, including on the forwarded path.
- Format masking:
  - RRR with ra=1, rb=2, rc=3 preloaded 0x11…, 0x22…, 0x33…. Required: ra_even=0x11…, rb_even=0x22…, rc_even=0x33….
  - Same registers via RI10 ra=1. Required: ra=0x11…, rb=0, rc=0.
  - Same via RI16. Required: all outputs 0.
- Mid-operation reset: assert reset on the same edge as an enabled write. Required: the write is dropped and all outputs are 0.

Source files
------------

// File: rtl/spu_register_table.sv
// Architectural register file for the dual-issue SPU: 128 x 128-bit registers.
// It decodes source fields from the even and odd instructions, returns registered operands
// one cycle later, and accepts one writeback per pipe per cycle. Same-cycle writes are
// forwarded to the reads, and the odd pipe wins when both pipes write the same address.
module spu_register_table #(
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned DATA_W   = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:31]       instr_even,
    input  logic [0:31]       instr_odd,
    input  logic [2:0]        format_even,
    input  logic [2:0]        format_odd,
    output logic [0:DATA_W-1] ra_even,
    output logic [0:DATA_W-1] rb_even,
    output logic [0:DATA_W-1] rc_even,
    output logic [0:DATA_W-1] ra_odd,
    output logic [0:DATA_W-1] rb_odd,
    input  logic [0:6]        rt_addr_even,
    input  logic [0:6]        rt_addr_odd,
    input  logic [0:DATA_W-1] rt_even,
    input  logic [0:DATA_W-1] rt_odd,
    input  logic              reg_write_even,
    input  logic              reg_write_odd
);

    typedef enum logic [2:0] {
        FmtRRR  = 3'd0,
        FmtRR   = 3'd1,
        FmtRI7  = 3'd2,
        FmtRI10 = 3'd3,
        FmtRI16 = 3'd4,
        FmtRI18 = 3'd5
    } fmt_e;

    logic [0:DATA_W-1] regs_q [NUM_REGS];

    // Source fields, big-endian bit numbering
    logic [0:6] ra_addr_even, rb_addr_even, rc_addr_even;
    logic [0:6] ra_addr_odd, rb_addr_odd;

    assign rb_addr_even = instr_even[11:17];
    assign ra_addr_even = instr_even[18:24];
    assign rc_addr_even = instr_even[25:31];
    assign rb_addr_odd  = instr_odd[11:17];
    assign ra_addr_odd  = instr_odd[18:24];

    // The opcode and rt fields are not register sources; the odd pipe has no rc
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_even[0:10], instr_odd[0:10], instr_odd[25:31]};

    logic use_ra_even, use_rb_even, use_rc_even;
    logic use_ra_odd, use_rb_odd;

    logic [0:DATA_W-1] ra_even_d, rb_even_d, rc_even_d, ra_odd_d, rb_odd_d;

    // Write data overrides the stored value; odd is checked first so it wins a same-address pair
    function automatic logic [0:DATA_W-1] bypass(
        input logic [0:6]        addr,
        input logic [0:DATA_W-1] stored,
        input logic              we_e,
        input logic [0:6]        wa_e,
        input logic [0:DATA_W-1] wd_e,
        input logic              we_o,
        input logic [0:6]        wa_o,
        input logic [0:DATA_W-1] wd_o
    );
        if (we_o && (wa_o == addr)) begin
            return wd_o;
        end else if (we_e && (wa_e == addr)) begin
            return wd_e;
        end
        return stored;
    endfunction

    // Decode which operands each format actually reads
    always_comb begin
        use_ra_even = 1'b0;
        use_rb_even = 1'b0;
        use_rc_even = 1'b0;
        use_ra_odd  = 1'b0;
        use_rb_odd  = 1'b0;
        case (format_even)
            FmtRRR: begin
                use_ra_even = 1'b1;
                use_rb_even = 1'b1;
                use_rc_even = 1'b1;
            end
            FmtRR: begin
                use_ra_even = 1'b1;
                use_rb_even = 1'b1;
            end
            FmtRI7, FmtRI10: use_ra_even = 1'b1;
            default: ;
        endcase
        case (format_odd)
            FmtRRR, FmtRR: begin
                use_ra_odd = 1'b1;
                use_rb_odd = 1'b1;
            end
            FmtRI7, FmtRI10: use_ra_odd = 1'b1;
            default: ;
        endcase
    end

    // Next operand values: the register (or bypassed write data), or zero when the operand is unused
    always_comb begin
        ra_even_d = '0;
        rb_even_d = '0;
        rc_even_d = '0;
        ra_odd_d  = '0;
        rb_odd_d  = '0;
        if (use_ra_even) begin
            ra_even_d = bypass(ra_addr_even, regs_q[ra_addr_even], reg_write_even, rt_addr_even,
                               rt_even, reg_write_odd, rt_addr_odd, rt_odd);
        end
        if (use_rb_even) begin
            rb_even_d = bypass(rb_addr_even, regs_q[rb_addr_even], reg_write_even, rt_addr_even,
                               rt_even, reg_write_odd, rt_addr_odd, rt_odd);
        end
        if (use_rc_even) begin
            rc_even_d = bypass(rc_addr_even, regs_q[rc_addr_even], reg_write_even, rt_addr_even,
                               rt_even, reg_write_odd, rt_addr_odd, rt_odd);
        end
        if (use_ra_odd) begin
            ra_odd_d = bypass(ra_addr_odd, regs_q[ra_addr_odd], reg_write_even, rt_addr_even,
                              rt_even, reg_write_odd, rt_addr_odd, rt_odd);
        end
        if (use_rb_odd) begin
            rb_odd_d = bypass(rb_addr_odd, regs_q[rb_addr_odd], reg_write_even, rt_addr_even,
                              rt_even, reg_write_odd, rt_addr_odd, rt_odd);
        end
    end

    // Register array; the odd write is issued last so it wins a same-address conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (reg_write_even) begin
                regs_q[rt_addr_even] <= rt_even;
            end
            if (reg_write_odd) begin
                regs_q[rt_addr_odd] <= rt_odd;
            end
        end
    end

    // Registered operand outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ra_even <= '0;
            rb_even <= '0;
            rc_even <= '0;
            ra_odd  <= '0;
            rb_odd  <= '0;
        end else begin
            ra_even <= ra_even_d;
            rb_even <= rb_even_d;
            rc_even <= rc_even_d;
            ra_odd  <= ra_odd_d;
            rb_odd  <= rb_odd_d;
        end
    end

endmodule

// File: tb/tb_spu_register_table.sv
// Self-checking bench for spu_register_table: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural register-file model.
module tb_spu_register_table;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:31]  instr_even, instr_odd;
    logic [2:0]   format_even, format_odd;
    logic [0:127] ra_even, rb_even, rc_even, ra_odd, rb_odd;
    logic [0:6]   rt_addr_even, rt_addr_odd;
    logic [0:127] rt_even, rt_odd;
    logic         reg_write_even, reg_write_odd;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [127:0] mdl_regs [128];
    logic [127:0] exp_ra_e, exp_rb_e, exp_rc_e, exp_ra_o, exp_rb_o;
    bit           exp_valid = 1'b0;

    always #5 clk = ~clk;

    spu_register_table dut (
        .clk           (clk),
        .reset         (reset),
        .instr_even    (instr_even),
        .instr_odd     (instr_odd),
        .format_even   (format_even),
        .format_odd    (format_odd),
        .ra_even       (ra_even),
        .rb_even       (rb_even),
        .rc_even       (rc_even),
        .ra_odd        (ra_odd),
        .rb_odd        (rb_odd),
        .rt_addr_even  (rt_addr_even),
        .rt_addr_odd   (rt_addr_odd),
        .rt_even       (rt_even),
        .rt_odd        (rt_odd),
        .reg_write_even(reg_write_even),
        .reg_write_odd (reg_write_odd)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Build an instruction word: opcode bits 0:3, rt 4:10, rb 11:17, ra 18:24, rc 25:31
    function automatic logic [31:0] mk(input int rt, input int rb, input int ra, input int rc);
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        return {op, 7'(rt), 7'(rb), 7'(ra), 7'(rc)};
    endfunction

    // Field whose last big-endian bit is 'last' (7 bits wide)
    function automatic int fld(input logic [31:0] w, input int last);
        return int'((w >> (31 - last)) & 32'h7f);
    endfunction

    // Value a read of 'addr' must see: write data of this edge (odd first), else stored value
    function automatic logic [127:0] rd(input int addr);
        if (reg_write_odd && int'(rt_addr_odd) == addr) return rt_odd;
        if (reg_write_even && int'(rt_addr_even) == addr) return rt_even;
        return mdl_regs[addr];
    endfunction

    // Advance one edge: predict outputs from current inputs, then update the model
    task automatic tick();
        logic [127:0] n_ra_e, n_rb_e, n_rc_e, n_ra_o, n_rb_o;
        int fe, fo;
        fe = int'(format_even);
        fo = int'(format_odd);
        n_ra_e = '0; n_rb_e = '0; n_rc_e = '0; n_ra_o = '0; n_rb_o = '0;
        if (!reset) begin
            if (fe <= 3) n_ra_e = rd(fld(instr_even, 24));
            if (fe <= 1) n_rb_e = rd(fld(instr_even, 17));
            if (fe == 0) n_rc_e = rd(fld(instr_even, 31));
            if (fo <= 3) n_ra_o = rd(fld(instr_odd, 24));
            if (fo <= 1) n_rb_o = rd(fld(instr_odd, 17));
        end
        @(posedge clk);
        exp_ra_e = n_ra_e; exp_rb_e = n_rb_e; exp_rc_e = n_rc_e;
        exp_ra_o = n_ra_o; exp_rb_o = n_rb_o;
        if (reset) begin
            for (int i = 0; i < 128; i++) mdl_regs[i] = '0;
        end else begin
            if (reg_write_even) mdl_regs[rt_addr_even] = rt_even;
            if (reg_write_odd) mdl_regs[rt_addr_odd] = rt_odd;
        end
        exp_valid = 1'b1;
        #1;
    endtask

    // Compare DUT outputs with the model on every cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("ra_even", ra_even, exp_ra_e);
            chk("rb_even", rb_even, exp_rb_e);
            chk("rc_even", rc_even, exp_rc_e);
            chk("ra_odd", ra_odd, exp_ra_o);
            chk("rb_odd", rb_odd, exp_rb_o);
        end
    end

    task automatic idle_inputs();
        instr_even = '0; instr_odd = '0;
        format_even = 3'd4; format_odd = 3'd4;
        rt_addr_even = '0; rt_addr_odd = '0;
        rt_even = '0; rt_odd = '0;
        reg_write_even = 1'b0; reg_write_odd = 1'b0;
    endtask

    initial begin
        logic [127:0] v1, v2, v3, v9, vaa, v55, ones;
        ones = '1;
        v1 = {16{8'h11}}; v2 = {16{8'h22}}; v3 = {16{8'h33}};
        v9 = {8{16'h1234}}; vaa = {16{8'hAA}}; v55 = {16{8'h55}};
        for (int i = 0; i < 128; i++) mdl_regs[i] = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset clears registers and outputs
        reg_write_even = 1'b1; rt_addr_even = 7'd7; rt_even = ones;
        tick();
        idle_inputs();
        instr_even = mk(0, 7, 7, 0); format_even = 3'd1;
        reset = 1'b1;
        tick();
        tick();
        chk("reset_ra_even", ra_even, '0);
        chk("reset_rb_even", rb_even, '0);
        reset = 1'b0;
        tick();
        chk("post_reset_reg7", ra_even, '0);

        // Basic write then read (shlh rb=3 ra=4 rt=5)
        idle_inputs();
        reg_write_even = 1'b1; rt_addr_even = 7'd5; rt_even = {16'h000A, 112'h0};
        instr_even = 32'h0BE0C205; format_even = 3'd1;
        tick();
        chk("basic_ra0", ra_even, '0);
        chk("basic_rb0", rb_even, '0);
        idle_inputs();
        instr_even = mk(0, 3, 5, 0); format_even = 3'd1;
        tick();
        chk("basic_ra5", ra_even, {16'h000A, 112'h0});
        chk("basic_rb3", rb_even, '0);

        // Same-edge write forwarding on the odd pipe
        idle_inputs();
        reg_write_odd = 1'b1; rt_addr_odd = 7'd9; rt_odd = v9;
        instr_odd = mk(0, 9, 9, 0); format_odd = 3'd1;
        tick();
        chk("fwd_ra_odd", ra_odd, v9);
        chk("fwd_rb_odd", rb_odd, v9);

        // Dual-write conflict: odd wins, both forwarded and stored
        idle_inputs();
        reg_write_even = 1'b1; rt_addr_even = 7'd20; rt_even = vaa;
        reg_write_odd = 1'b1; rt_addr_odd = 7'd20; rt_odd = v55;
        instr_even = mk(0, 20, 20, 0); format_even = 3'd1;
        tick();
        chk("conflict_fwd", ra_even, v55);
        idle_inputs();
        instr_odd = mk(0, 20, 20, 0); format_odd = 3'd0;
        tick();
        chk("conflict_read", ra_odd, v55);
        chk("conflict_read_rb", rb_odd, v55);

        // Format masking
        idle_inputs();
        reg_write_even = 1'b1; rt_addr_even = 7'd1; rt_even = v1;
        reg_write_odd = 1'b1; rt_addr_odd = 7'd2; rt_odd = v2;
        tick();
        idle_inputs();
        reg_write_even = 1'b1; rt_addr_even = 7'd3; rt_even = v3;
        tick();
        idle_inputs();
        instr_even = mk(0, 2, 1, 3); format_even = 3'd0;
        tick();
        chk("rrr_ra", ra_even, v1);
        chk("rrr_rb", rb_even, v2);
        chk("rrr_rc", rc_even, v3);
        format_even = 3'd3;
        tick();
        chk("ri10_ra", ra_even, v1);
        chk("ri10_rb", rb_even, '0);
        chk("ri10_rc", rc_even, '0);
        format_even = 3'd4;
        tick();
        chk("ri16_ra", ra_even, '0);
        chk("ri16_rb", rb_even, '0);
        chk("ri16_rc", rc_even, '0);

        // Reset on the same edge as an enabled write
        idle_inputs();
        reg_write_even = 1'b1; rt_addr_even = 7'd1; rt_even = ones;
        instr_even = mk(0, 2, 1, 3); format_even = 3'd0;
        reset = 1'b1;
        tick();
        chk("midrst_ra", ra_even, '0);
        chk("midrst_rc", rc_even, '0);
        reset = 1'b0;
        idle_inputs();
        instr_even = mk(0, 1, 1, 1); format_even = 3'd0;
        tick();
        chk("midrst_dropped", ra_even, '0);

        // Randomized traffic, small address pool so aliasing and forwarding are frequent
        for (int n = 0; n < 3000; n++) begin
            int pool;
            pool = ($urandom_range(0, 3) == 0) ? 127 : 7;
            instr_even = mk($urandom_range(0, pool), $urandom_range(0, pool),
                            $urandom_range(0, pool), $urandom_range(0, pool));
            instr_odd = mk($urandom_range(0, pool), $urandom_range(0, pool),
                           $urandom_range(0, pool), $urandom_range(0, pool));
            format_even = 3'($urandom_range(0, 7));
            format_odd = 3'($urandom_range(0, 7));
            reg_write_even = 1'($urandom_range(0, 1));
            reg_write_odd = 1'($urandom_range(0, 1));
            rt_addr_even = 7'($urandom_range(0, pool));
            rt_addr_odd = 7'($urandom_range(0, pool));
            rt_even = {$urandom, $urandom, $urandom, $urandom};
            rt_odd = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
